stopwatch_core: RTL

//   Stopwatch counter stage with start/stop, clear and lap-hold control.

---
 rtl/stopwatch_core.sv | 128 ++++++++++++
 1 files changed

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - stopwatch counter stage with start/stop, clear and lap hold
// Optional lap-hold logic is built when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int CSEC_DIV = CLK_FREQ / 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic [7:0] csec,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic       running,
    output logic       lap_hold
);

    localparam int PW = $clog2(CSEC_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CSEC_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [PW-1:0] presc;
    logic [6:0]    live_csec, live_sec, live_min;
    logic [6:0]    nxt_csec, nxt_sec, nxt_min;
    logic          tick;
    logic          clear_act;
    logic          lap_act;
    logic          show_live;

    assign tick      = (state == ST_RUN) && (presc == PRESC_MAX);
    assign clear_act = (state == ST_PAUSE) && btn_clear;

    always_comb begin
        nxt_csec = live_csec;
        nxt_sec  = live_sec;
        nxt_min  = live_min;
        if (tick) begin
            if (live_csec == 7'd99) begin
                nxt_csec = 7'd0;
                if (live_sec == 7'd59) begin
                    nxt_sec = 7'd0;
                    nxt_min = (live_min == 7'd59) ? 7'd0 : live_min + 7'd1;
                end else begin
                    nxt_sec = live_sec + 7'd1;
                end
            end else begin
                nxt_csec = live_csec + 7'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (btn_start) state_nxt = ST_RUN;
            ST_RUN:   if (btn_start) state_nxt = ST_PAUSE;
            ST_PAUSE: begin
                // clear wins over a simultaneous start
                if (btn_clear)      state_nxt = ST_IDLE;
                else if (btn_start) state_nxt = ST_RUN;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

`ifdef STOPWATCH_LAP_EN
    assign lap_act   = btn_lap && (((state == ST_RUN) && !btn_start) ||
                                   ((state == ST_PAUSE) && !btn_clear));
    assign show_live = !lap_hold || lap_act;

    always_ff @(posedge clk) begin
        if (!reset_n || clear_act) lap_hold <= 1'b0;
        else if (lap_act)          lap_hold <= !lap_hold;
    end
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign lap_act    = 1'b0;
    assign show_live  = 1'b1;
    assign lap_hold   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            running   <= 1'b0;
            presc     <= '0;
            live_csec <= 7'd0;
            live_sec  <= 7'd0;
            live_min  <= 7'd0;
            csec      <= 8'd0;
            sec       <= 8'd0;
            min       <= 8'd0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == ST_RUN);
            if (clear_act) begin
                presc     <= '0;
                live_csec <= 7'd0;
                live_sec  <= 7'd0;
                live_min  <= 7'd0;
                csec      <= 8'd0;
                sec       <= 8'd0;
                min       <= 8'd0;
            end else begin
                // prescaler is only touched in RUN so a pause keeps the fraction
                if (state == ST_RUN) begin
                    presc     <= tick ? '0 : presc + PW'(1);
                    live_csec <= nxt_csec;
                    live_sec  <= nxt_sec;
                    live_min  <= nxt_min;
                end
                if (show_live) begin
                    csec <= {1'b0, live_csec};
                    sec  <= {1'b0, live_sec};
                    min  <= {1'b0, live_min};
                end
            end
        end
    end

endmodule
